// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response handshakes for both arbiter ports.
// master = requester/consumer side, slave = arbiter side.
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [3:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [3:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [31:0] rsp0_data;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [31:0] rsp1_data;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data,
    input  rsp1_valid, rsp1_data,
    output rsp0_ready, rsp1_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data,
    output rsp1_valid, rsp1_data,
    input  rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two request ports time-sharing one ALU.
// One op in flight per port; results held until consumed.
module alu_arbiter #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output logic         busy
);
  logic        pend0, pend1, last_grant;
  logic        elig0, elig1, gnt0, gnt1;
  logic        hs0, hs1;
  logic        iss_valid, iss_port;
  logic [3:0]  iss_op;
  logic [31:0] iss_a, iss_b;
  logic [31:0] alu_y;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;

  assign bus.req0_ready = ~pend0 & ~rst;
  assign bus.req1_ready = ~pend1 & ~rst;
  assign bus.rsp0_valid = rsp0_valid;
  assign bus.rsp1_valid = rsp1_valid;
  assign bus.rsp0_data  = rsp0_data;
  assign bus.rsp1_data  = rsp1_data;
  assign busy = pend0 | pend1;

  assign elig0 = bus.req0_valid & ~pend0 & ~rst;
  assign elig1 = bus.req1_valid & ~pend1 & ~rst;
  // last_grant = 1 means port 1 won last, so port 0 wins a tie
  assign gnt0 = elig0 & (~elig1 | PRIO_FIXED | last_grant);
  assign gnt1 = elig1 & ~gnt0;

  assign hs0 = rsp0_valid & bus.rsp0_ready;
  assign hs1 = rsp1_valid & bus.rsp1_ready;

  // The shared ALU; opcodes 9-15 fall to zero
  always_comb begin
    alu_y = '0;
    unique case (iss_op)
      4'd0:    alu_y = iss_a + iss_b;
      4'd1:    alu_y = iss_a - iss_b;
      4'd2:    alu_y = iss_a & iss_b;
      4'd3:    alu_y = iss_a | iss_b;
      4'd4:    alu_y = iss_a ^ iss_b;
      4'd5:    alu_y = iss_a << iss_b[4:0];
      4'd6:    alu_y = iss_a >> iss_b[4:0];
      4'd7:    alu_y = $signed(iss_a) >>> iss_b[4:0];
      4'd8:    alu_y = {31'd0, iss_a < iss_b};
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend0      <= 1'b0;
      pend1      <= 1'b0;
      last_grant <= 1'b1;
      iss_valid  <= 1'b0;
      iss_port   <= 1'b0;
      iss_op     <= '0;
      iss_a      <= '0;
      iss_b      <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      iss_valid <= gnt0 | gnt1;
      if (gnt0 | gnt1) begin
        iss_port   <= gnt1;
        iss_op     <= gnt1 ? bus.req1_op : bus.req0_op;
        iss_a      <= gnt1 ? bus.req1_a  : bus.req0_a;
        iss_b      <= gnt1 ? bus.req1_b  : bus.req0_b;
        last_grant <= gnt1;
      end

      if (gnt0)     pend0 <= 1'b1;
      else if (hs0) pend0 <= 1'b0;
      if (gnt1)     pend1 <= 1'b1;
      else if (hs1) pend1 <= 1'b0;

      // pend keeps the target slot empty, so the write never collides
      if (iss_valid & ~iss_port) begin
        rsp0_valid <= 1'b1;
        rsp0_data  <= alu_y;
      end else if (hs0) begin
        rsp0_valid <= 1'b0;
      end
      if (iss_valid & iss_port) begin
        rsp1_valid <= 1'b1;
        rsp1_data  <= alu_y;
      end else if (hs1) begin
        rsp1_valid <= 1'b0;
      end
    end
  end
endmodule
